// File: rtl/bram_tdp_port_arbiter_pkg.sv
// Shared types and helpers for the BRAM true-dual-port port arbiter.
//   arb_state_e   : arbiter FSM states (CLEAR sweep, RUN)
//   RD_LATENCY    : cycles from read accept to response strobe
//   unpack_slice  : extracts requester idx's w-bit field from a packed vector
package bram_arb_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

    localparam int unsigned RD_LATENCY  = 2;
    localparam int unsigned MAX_VEC_W   = 2048;
    localparam int unsigned MAX_SLICE_W = 256;

    // Caller zero-extends the packed vector to MAX_VEC_W and narrows the result.
    function automatic logic [MAX_SLICE_W-1:0] unpack_slice(
        input logic [MAX_VEC_W-1:0] vec,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [MAX_VEC_W-1:0] shifted;
        logic [MAX_VEC_W-1:0] mask;
        shifted = vec >> (idx * w);
        mask    = (MAX_VEC_W'(1) << w) - MAX_VEC_W'(1);
        return MAX_SLICE_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/bram_tdp_port_arbiter_if.sv
// Requester-side and BRAM-side bus of one arbiter instance.
//   master : environment (requesters + BRAM read data)
//   slave  : the arbiter
//   req_*  : per-requester packed valid/ready/we/addr/wd
//   rsp_*  : one-hot read strobe and shared read data
//   bram_* : one BRAM port (read channel rce/ra/rq, write channel wce/wa/wd)
interface bram_tdp_port_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned AWIDTH = 9,
    parameter int unsigned DWIDTH = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*AWIDTH-1:0] req_addr;
    logic [N_REQ*DWIDTH-1:0] req_wd;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DWIDTH-1:0]       rsp_data;
    logic                    busy;
    logic                    bram_rce;
    logic [AWIDTH-1:0]       bram_ra;
    logic [DWIDTH-1:0]       bram_rq;
    logic                    bram_wce;
    logic [AWIDTH-1:0]       bram_wa;
    logic [DWIDTH-1:0]       bram_wd;

    modport master (
        output req_valid, req_we, req_addr, req_wd, bram_rq,
        input  req_ready, rsp_valid, rsp_data, busy,
               bram_rce, bram_ra, bram_wce, bram_wa, bram_wd
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wd, bram_rq,
        output req_ready, rsp_valid, rsp_data, busy,
               bram_rce, bram_ra, bram_wce, bram_wa, bram_wd
    );
endinterface

// File: rtl/bram_tdp_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from (last grant + 1) mod N.
//   clk, rst        : clock, synchronous active-high reset
//   i_req           : request vector
//   i_advance       : allows the pointer to move onto the current grant
//   o_grant_c       : one-hot grant (combinational)
//   o_grant_idx_c   : grant index (combinational, valid when o_grant_c != 0)
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant_c,
    output logic [IW-1:0] o_grant_idx_c
);

    logic [IW-1:0] r_last;
    logic [IW-1:0] w_cand;
    logic          w_found;

    // First requester at or after last+1, wrapping.
    always_comb begin
        o_grant_c     = '0;
        o_grant_idx_c = '0;
        w_cand        = '0;
        w_found       = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = IW'((32'(r_last) + 32'd1 + k) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found           = 1'b1;
                o_grant_c[w_cand] = 1'b1;
                o_grant_idx_c     = w_cand;
            end
        end
    end

    // Reset to N-1 so requester 0 has priority first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= IW'(N - 1);
        end else if (i_advance && w_found) begin
            r_last <= o_grant_idx_c;
        end
    end

endmodule

// File: rtl/bram_tdp_port_arbiter.sv
// Shares one BRAM port among N_REQ requesters: one read and one write grant
// per cycle, each from its own round-robin arbiter; read data is strobed back
// to the issuing requester RD_LATENCY cycles after accept.
// Optional macro BRAM_ARB_CLEAR_ON_RESET_EN: after reset, sweep-write zeros
// to every address before accepting requests.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bram_tdp_port_arbiter_if.slave (requester and BRAM signals)
module bram_tdp_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned AWIDTH = 9,
    parameter int unsigned DWIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    bram_tdp_port_arbiter_if.slave bus
);

    localparam int unsigned IW = $clog2(N_REQ);
`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
    localparam arb_state_e RESET_STATE = CLEAR;
`else
    localparam arb_state_e RESET_STATE = RUN;
`endif

    arb_state_e                         r_state;
    arb_state_e                         w_state_next;
    logic                               w_active;
    logic                               w_clr_last;
    logic [AWIDTH-1:0]                  w_clr_addr;
    logic [N_REQ-1:0]                   w_rd_gnt;
    logic [N_REQ-1:0]                   w_wr_gnt;
    logic [IW-1:0]                      w_rd_idx;
    logic [IW-1:0]                      w_wr_idx;
    logic                               w_rd_any;
    logic                               w_wr_any;
    logic [AWIDTH-1:0]                  w_rd_addr;
    logic [AWIDTH-1:0]                  w_wr_addr;
    logic [DWIDTH-1:0]                  w_wr_wd;
    logic                               r_bram_rce;
    logic [AWIDTH-1:0]                  r_bram_ra;
    logic                               r_bram_wce;
    logic [AWIDTH-1:0]                  r_bram_wa;
    logic [DWIDTH-1:0]                  r_bram_wd;
    logic [RD_LATENCY-1:0][N_REQ-1:0]   r_rd_pipe;
    logic                               r_busy;

`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
    logic [AWIDTH-1:0] r_clr_addr;

    // Sweep address; restarts at 0 on every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_addr <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_addr <= r_clr_addr + AWIDTH'(1);
        end
    end

    assign w_clr_addr = r_clr_addr;
    assign w_clr_last = (r_clr_addr == {AWIDTH{1'b1}});
`else
    assign w_clr_addr = '0;
    assign w_clr_last = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR:   if (w_clr_last) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    // Grants are suppressed in CLEAR and while reset is held so no handshake is lost.
    assign w_active = (r_state == RUN) && !rst;

    rr_arbiter #(.N(N_REQ)) u_rd_arb (
        .clk           (clk),
        .rst           (rst),
        .i_req         (bus.req_valid & ~bus.req_we & {N_REQ{w_active}}),
        .i_advance     (w_active),
        .o_grant_c     (w_rd_gnt),
        .o_grant_idx_c (w_rd_idx)
    );

    rr_arbiter #(.N(N_REQ)) u_wr_arb (
        .clk           (clk),
        .rst           (rst),
        .i_req         (bus.req_valid & bus.req_we & {N_REQ{w_active}}),
        .i_advance     (w_active),
        .o_grant_c     (w_wr_gnt),
        .o_grant_idx_c (w_wr_idx)
    );

    assign w_rd_any  = |w_rd_gnt;
    assign w_wr_any  = |w_wr_gnt;
    assign w_rd_addr = AWIDTH'(unpack_slice(MAX_VEC_W'(bus.req_addr), 32'(w_rd_idx), AWIDTH));
    assign w_wr_addr = AWIDTH'(unpack_slice(MAX_VEC_W'(bus.req_addr), 32'(w_wr_idx), AWIDTH));
    assign w_wr_wd   = DWIDTH'(unpack_slice(MAX_VEC_W'(bus.req_wd), 32'(w_wr_idx), DWIDTH));

    // BRAM command registers, read-tag pipeline and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bram_rce <= 1'b0;
            r_bram_ra  <= '0;
            r_bram_wce <= 1'b0;
            r_bram_wa  <= '0;
            r_bram_wd  <= '0;
            r_rd_pipe  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_bram_rce <= w_rd_any;
            r_bram_ra  <= w_rd_any ? w_rd_addr : '0;
            if (r_state == CLEAR) begin
                r_bram_wce <= 1'b1;
                r_bram_wa  <= w_clr_addr;
                r_bram_wd  <= '0;
            end else begin
                r_bram_wce <= w_wr_any;
                r_bram_wa  <= w_wr_any ? w_wr_addr : '0;
                r_bram_wd  <= w_wr_any ? w_wr_wd : '0;
            end
            // One-hot tag of each read travels alongside the BRAM latency.
            r_rd_pipe  <= {r_rd_pipe[RD_LATENCY-2:0], w_rd_gnt};
            r_busy     <= w_rd_any | (|r_rd_pipe[RD_LATENCY-2:0]);
        end
    end

    assign bus.req_ready = w_rd_gnt | w_wr_gnt;
    assign bus.rsp_valid = r_rd_pipe[RD_LATENCY-1];
    assign bus.rsp_data  = bus.bram_rq;
    assign bus.busy      = r_busy | (r_state == CLEAR);
    assign bus.bram_rce  = r_bram_rce;
    assign bus.bram_ra   = r_bram_ra;
    assign bus.bram_wce  = r_bram_wce;
    assign bus.bram_wa   = r_bram_wa;
    assign bus.bram_wd   = r_bram_wd;

endmodule
